// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one digit per cycle, MSD first, acc = acc*10 + digit.
// Flags non-decimal nibbles and results above MAX_VAL; the result is held until out_ready.
module bcd_to_bin_seq #(
   parameter int DIGITS  = 2,
   parameter int OUT_W   = 7,
   parameter int MAX_VAL = 99
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] BCD_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    Data_out,
   output logic                err_digit,
   output logic                err_range
);

   localparam int ACC_W = $clog2(10**DIGITS);
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t              state, state_next;
   logic [4*DIGITS-1:0] shift_q, shift_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dig_err_q, dig_err_d;
   logic                out_valid_d;
   logic [OUT_W-1:0]    data_d;
   logic                err_digit_d, err_range_d;

   logic [3:0]          digit;
   logic [ACC_W-1:0]    acc_step;
   logic                flag_step;
   logic                range_step;

   assign in_ready = (state == IDLE);

   // Invalid nibbles may wrap the accumulator; harmless because such results are forced to 0.
   assign digit      = shift_q[4*DIGITS-1 -: 4];
   assign acc_step   = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
   assign flag_step  = dig_err_q | (digit > 4'd9);
   assign range_step = !flag_step && (acc_step > MAX_ACC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         dig_err_q <= 1'b0;
         out_valid <= 1'b0;
         Data_out  <= '0;
         err_digit <= 1'b0;
         err_range <= 1'b0;
      end else begin
         state     <= state_next;
         shift_q   <= shift_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dig_err_q <= dig_err_d;
         out_valid <= out_valid_d;
         Data_out  <= data_d;
         err_digit <= err_digit_d;
         err_range <= err_range_d;
      end
   end

   // Result registers are loaded on the same edge that processes the last digit.
   always_comb begin
      state_next  = state;
      shift_d     = shift_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      dig_err_d   = dig_err_q;
      out_valid_d = out_valid;
      data_d      = Data_out;
      err_digit_d = err_digit;
      err_range_d = err_range;

      case (state)
         IDLE: begin
            if (in_valid) begin
               shift_d    = BCD_in;
               acc_d      = '0;
               cnt_d      = CNT_W'(DIGITS);
               dig_err_d  = 1'b0;
               state_next = CONV;
            end
         end
         CONV: begin
            acc_d     = acc_step;
            dig_err_d = flag_step;
            shift_d   = shift_q << 4;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_next  = DONE;
               out_valid_d = 1'b1;
               err_digit_d = flag_step;
               err_range_d = range_step;
               data_d      = (flag_step || range_step) ? '0 : OUT_W'(acc_step);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_next  = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 2-digit min/sec instance and a 3-digit instance,
// driven from vector tables with expected results queued on acceptance.
module tb_bcd_to_bin_seq;

   typedef struct {
      logic [7:0] bcd;
      int         data;
      int         ed;
      int         er;
   } vec2_t;

   typedef struct {
      logic [11:0] bcd;
      int          data;
      int          ed;
      int          er;
   } vec3_t;

   typedef struct {
      int data;
      int ed;
      int er;
      int acceptEdge;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, err_digit2, err_range2;
   logic [7:0]  BCD_in2;
   logic [6:0]  Data_out2;

   logic        in_valid3, in_ready3, out_valid3, out_ready3, err_digit3, err_range3;
   logic [11:0] BCD_in3;
   logic [9:0]  Data_out3;

   int   checkCount;
   int   failCount;
   int   cycleNo;
   exp_t q2[$];
   exp_t q3[$];

   bcd_to_bin_seq #(.DIGITS(2), .OUT_W(7), .MAX_VAL(59)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .BCD_in    (BCD_in2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .Data_out  (Data_out2),
      .err_digit (err_digit2),
      .err_range (err_range2)
   );

   bcd_to_bin_seq #(.DIGITS(3), .OUT_W(10), .MAX_VAL(999)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .BCD_in    (BCD_in3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .Data_out  (Data_out3),
      .err_digit (err_digit3),
      .err_range (err_range3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycleNo = 0;
   always @(posedge clk) cycleNo <= cycleNo + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checkCount++;
      if (act != exp) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Handshake one value into the 2-digit instance and measure latency to out_valid.
   task automatic applyStimulus2(input logic [7:0] bcd, input int expData, input int expEd, input int expEr);
      int waitCycles;
      int lat;
      exp_t e;
      waitCycles = 0;
      while (!in_ready2 && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      check("accept_ready2", int'(in_ready2), 1);
      BCD_in2   = bcd;
      in_valid2 = 1'b1;
      e.data = expData;
      e.ed = expEd;
      e.er = expEr;
      e.acceptEdge = cycleNo + 1;
      q2.push_back(e);
      @(negedge clk);
      in_valid2 = 1'b0;
      BCD_in2   = 8'hFF;
      lat = 0;
      while (!out_valid2 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency2", lat, 2);
   endtask

   task automatic checkOutput2(input string name);
      exp_t e;
      if (q2.size() == 0) begin
         checkCount++;
         failCount++;
         $display("[TB] FAIL %s_queue actual=empty required=entry", name);
      end else begin
         e = q2.pop_front();
         check({name, "_valid"}, int'(out_valid2), 1);
         check({name, "_data"}, int'(Data_out2), e.data);
         check({name, "_err_digit"}, int'(err_digit2), e.ed);
         check({name, "_err_range"}, int'(err_range2), e.er);
      end
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
      check({name, "_valid_drop"}, int'(out_valid2), 0);
      check({name, "_ready_back"}, int'(in_ready2), 1);
   endtask

   task automatic driveAll3(input vec3_t v[5]);
      int waitCycles;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         BCD_in3   = v[i].bcd;
         in_valid3 = 1'b1;
         waitCycles = 0;
         while (!in_ready3 && waitCycles < 60) begin
            @(negedge clk);
            waitCycles++;
         end
         check("accept_ready3", int'(in_ready3), 1);
         e.data = v[i].data;
         e.ed = v[i].ed;
         e.er = v[i].er;
         e.acceptEdge = cycleNo + 1;
         q3.push_back(e);
         @(negedge clk);
      end
      in_valid3 = 1'b0;
   endtask

   task automatic monitor3(input int count);
      int waitCycles;
      exp_t e;
      for (int i = 0; i < count; i++) begin
         waitCycles = 0;
         while (!out_valid3 && waitCycles < 60) begin
            @(negedge clk);
            waitCycles++;
         end
         if (!out_valid3 || q3.size() == 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL out3_%0d actual=no_output required=output", i);
         end else begin
            e = q3.pop_front();
            check("latency3", cycleNo - e.acceptEdge, 3);
            check("data3", int'(Data_out3), e.data);
            check("err_digit3", int'(err_digit3), e.ed);
            check("err_range3", int'(err_range3), e.er);
         end
         @(negedge clk);
         check("handshake3", int'(out_valid3), 0);
      end
   endtask

   initial begin : main
      vec2_t vec2[9];
      vec3_t vec3[5];
      int seen;

      vec2[0] = '{8'h45, 45, 0, 0};
      vec2[1] = '{8'h59, 59, 0, 0};
      vec2[2] = '{8'h60,  0, 0, 1};
      vec2[3] = '{8'h3A,  0, 1, 0};
      vec2[4] = '{8'h00,  0, 0, 0};
      vec2[5] = '{8'hA0,  0, 1, 0};
      vec2[6] = '{8'h99,  0, 0, 1};
      vec2[7] = '{8'h15, 15, 0, 0};
      vec2[8] = '{8'h09,  9, 0, 0};

      vec3[0] = '{12'h999, 999, 0, 0};
      vec3[1] = '{12'h123, 123, 0, 0};
      vec3[2] = '{12'h5A0,   0, 1, 0};
      vec3[3] = '{12'h000,   0, 0, 0};
      vec3[4] = '{12'h100, 100, 0, 0};

      checkCount = 0;
      failCount  = 0;
      rst_n = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; BCD_in2 = 8'h00;
      in_valid3 = 1'b0; out_ready3 = 1'b0; BCD_in3 = 12'h000;

      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready2), 1);
      check("rst_out_valid", int'(out_valid2), 0);
      check("rst_data", int'(Data_out2), 0);
      check("rst_err_digit", int'(err_digit2), 0);
      check("rst_err_range", int'(err_range2), 0);
      check("rst_in_ready3", int'(in_ready3), 1);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] table vectors, 2-digit instance");
      for (int i = 0; i < 9; i++) begin
         applyStimulus2(vec2[i].bcd, vec2[i].data, vec2[i].ed, vec2[i].er);
         checkOutput2($sformatf("vec2_%0d", i));
      end

      $display("[TB] output stall with in_valid during DONE");
      applyStimulus2(8'h23, 23, 0, 0);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            in_valid2 = 1'b1;
            BCD_in2   = 8'h11;
         end
         if (c == 6) in_valid2 = 1'b0;
         check("hold_valid", int'(out_valid2), 1);
         check("hold_data", int'(Data_out2), 23);
         check("hold_in_ready", int'(in_ready2), 0);
         @(negedge clk);
      end
      checkOutput2("hold");
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid2) seen = 1;
      end
      check("no_accept_in_done", seen, 0);
      check("hold_data_kept", int'(Data_out2), 23);

      $display("[TB] asynchronous reset mid-conversion");
      BCD_in2   = 8'h99;
      in_valid2 = 1'b1;
      check("rst_seq_ready", int'(in_ready2), 1);
      @(negedge clk);
      in_valid2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_data", int'(Data_out2), 0);
      check("async_valid", int'(out_valid2), 0);
      check("async_in_ready", int'(in_ready2), 1);
      check("async_err_range", int'(err_range2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid2) seen = 1;
      end
      check("rst_no_pulse", seen, 0);
      check("rst_ready_after", int'(in_ready2), 1);

      $display("[TB] back-to-back, 3-digit instance");
      out_ready3 = 1'b1;
      fork
         driveAll3(vec3);
         monitor3(5);
      join
      out_ready3 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter, the reverse of the time-display binary-to-BCD path.
- Takes a packed multi-digit BCD value, most significant digit first, from the time-set and button-entry logic.
- Returns the binary value for the hours, minutes and seconds counters.
- Iterative: each cycle computes acc = acc*10 + digit. Valid/ready handshake on both sides; digit-validity and range checking included.

Parameters:
- DIGITS, 2, number of BCD digits in BCD_in (1..4).
- OUT_W, 7, width of Data_out. Must satisfy 2^OUT_W > 10^DIGITS - 1.
- MAX_VAL, 99, largest legal result. Use 59 for min/sec instances and 23 for hour instances.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  BCD_in is valid this cycle.
- in_ready  out  1  block can accept an input.
- BCD_in  in  4*DIGITS  packed BCD; top nibble is the most significant digit.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- Data_out  out  OUT_W  binary result.
- err_digit  out  1  a nibble was greater than 9; qualified by out_valid.
- err_range  out  1  result is greater than MAX_VAL; qualified by out_valid.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE, in_ready=1, out_valid=0, Data_out=0, err_digit=0, err_range=0.
  - Internal shift register, accumulator and digit counter cleared.
  - Reset asserted mid-conversion or in DONE discards the operation; no out_valid pulse follows.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture BCD_in into the shift register, acc=0, cnt=DIGITS, digit-error flag=0; go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: d = top nibble. acc = acc*10 + d, computed as (acc<<3)+(acc<<1)+d.
  - If d > 9, set the digit-error flag; arithmetic still proceeds.
  - Shift the register left by 4; cnt = cnt - 1.
  - On the cycle processing the last digit (cnt==1), go to DONE and register the outputs on that same edge:
    - err_digit = flag.
    - err_range = (not flag) and (final acc > MAX_VAL).
    - Data_out = final acc if neither error is set, else 0.
    - out_valid = 1.
- Latency: the handshake edge is E0. out_valid is high after edge E_DIGITS (2 cycles for DIGITS=2).
- Throughput: one conversion per DIGITS+2 cycles (accept, DIGITS convert, DONE, back to IDLE).
- Accumulator width: ceil(log2(10^DIGITS)) bits, internal only, so it never overflows.
  - Data_out = acc[OUT_W-1:0]; the OUT_W rule above guarantees no truncation.
- DONE:
  - out_valid, Data_out and error flags held stable while out_ready=0, for an unlimited time.
  - On out_ready=1: out_valid=0 and go to IDLE at the next edge.
  - in_ready rises one cycle after the output handshake. No same-cycle bypass; in_valid during DONE is ignored, and the producer must hold it.
- After the output handshake, Data_out and the error flags keep their last values until the next DONE entry.
- in_valid while in_ready=0 has no effect.
- BCD_in changing after capture has no effect.
- err_digit and err_range are never both 1.

Test Plan:
- DIGITS=2, MAX_VAL=59:
  - Reset, then BCD_in=8'h45 with in_valid pulse → out_valid 2 cycles after acceptance, Data_out=7'd45 (0x2D), both errors 0.
  - BCD_in=8'h59 → Data_out=59, no error.
  - BCD_in=8'h60 → err_range=1, Data_out=0.
- BCD_in=8'h3A → err_digit=1, err_range=0, Data_out=0.
- out_ready held 0 for 10 cycles after 8'h23 → out_valid, Data_out=23 and in_ready=0 stable throughout.
  - Raise out_ready → out_valid=0 next edge; in_ready=1 the following cycle.
  - A new in_valid during DONE is not accepted.
- Assert rst_n=0 one cycle after accepting 8'h99 → all outputs 0 immediately (asynchronous), in_ready=1 after release, no out_valid pulse.
- DIGITS=3, OUT_W=10, MAX_VAL=999: BCD_in=12'h999 → Data_out=999 after 3 cycles.
  - Back-to-back 12'h000 / 12'h100 → 0 then 100, each handshake honoured.
